shift_pipe: RTL
===============

Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the integer execute path.
- Performs RV-style SLL/SRL/SRA, plus optional rotates, on XLEN-wide operands.
- Uses a valid/ready handshake with full backpressure and a tag carried alongside each operation.
- Shift amount is split across PIPE_STAGES register stages so wide XLEN closes timing.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.
- PIPE_STAGES, 2, number of register stages, 1 or 2; other values are a compile-time error.
- TAG_W, 4, width of the opaque tag carried with each operation.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discards every in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR.
- in_data  input  XLEN  operand.
- in_shamt  input  SHW  shift amount, 0..XLEN-1.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_data  output  XLEN  result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear; out_valid, out_data and out_tag are 0. in_ready is combinationally 1 while the pipe is empty.
- Stage split:
  - PIPE_STAGES=1: the full shift completes in one register stage; latency is 1 cycle from accept to out_valid.
  - PIPE_STAGES=2: stage 1 applies shamt bits [SHW-1:SHW/2]; stage 2 applies bits [SHW/2-1:0]; latency is 2 cycles.
- Register contents per stage: valid, partial data, op, remaining shamt bits, tag, and the sign bit of the original operand.
- Advance rule: stage k loads when stage k is empty or stage k advances this cycle. The last stage advances on out_valid && out_ready.
  - in_ready = !s1_valid || s1_advance. Bubbles compress, so throughput is 1 op/cycle with out_ready held high.
- out_valid = valid bit of the last stage. out_data and out_tag hold stable while out_valid && !out_ready.
- SRA fill uses the original operand's bit XLEN-1, carried through every stage, not the partial result.
- Shift by 0 returns in_data unchanged for all ops.
- Illegal op (101..111), and ROL/ROR when the rotate feature is compiled out: data passes through unshifted. No error flag.
- Flush: all valids clear on the next edge. A request presented in the same cycle as flush is dropped, even if in_ready is high. in_ready is unaffected by flush.
- Results are ordered strictly in acceptance order. No operation is ever duplicated or lost except through flush or reset.
- Reset mid-operation: all in-flight ops are lost; the first request after rst_n deasserts is accepted normally.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
  - Defined: ops 011 (ROL) and 100 (ROR) rotate by shamt, with wrapped bits re-entering from the opposite end in every stage.
  - Undefined: rotate logic is not built, and 011/100 behave as illegal ops (pass-through).

Decomposition:
- Shared package shift_pkg holds:
  - op encodings as localparams: OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR;
  - the op field width constant (3);
  - a packed struct for stage payload: data, op, shamt, tag, sign.
- One natural sub-module: shift_stage.
  - Combinational shift by a sub-range of shamt bits for all ops.
  - Parameters: XLEN, LO_BIT, HI_BIT.
  - Instantiated PIPE_STAGES times.

Test Plan:
- XLEN=32: SLL 0x00000001 by 31 -> 0x80000000; SRL 0x80000000 by 31 -> 0x00000001; SRA 0x80000000 by 31 -> 0xFFFFFFFF; each with out_valid exactly PIPE_STAGES cycles after accept.
- Back-to-back stream of 8 ops with tags 0..7, out_ready=1 -> 8 results on 8 consecutive cycles, tags 0..7 in order.
- out_ready held low for 4 cycles while 3 requests are offered (PIPE_STAGES=2):
  - the first two are accepted and in_ready drops;
  - out_data/out_tag stay stable while stalled;
  - after release, results drain in order and the third is accepted.
- flush asserted with 2 ops in flight and in_valid=1 -> no out_valid for those 3 ops; the next request completes normally.
- Rotate feature: with SHIFT_ROTATE_EN, ROR 0x12345678 by 8 -> 0x78123456 and ROL 0x12345678 by 4 -> 0x23456781. Without the macro, both return 0x12345678.
- rst_n pulsed low with the pipe full and out_ready=0 -> out_valid=0, out_data=0, out_tag=0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: operation encodings and small helpers shared by the shift_pipe
// datapath and its combinational stage.
package shift_pkg;

    // Width of the operation field on the request interface.
    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    // Operation encodings. 101..111 are unassigned and pass data through.
    localparam op_t OP_SLL = 3'b000;
    localparam op_t OP_SRL = 3'b001;
    localparam op_t OP_SRA = 3'b010;
    localparam op_t OP_ROL = 3'b011;
    localparam op_t OP_ROR = 3'b100;

    // True when v is a positive power of two; used for parameter checks.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage : shift_pkg

// File: rtl/shift_stage.sv
// shift_stage: combinational shift of a partial operand by the shamt bits
// [HI_BIT:LO_BIT]. Chaining stages over disjoint bit ranges composes into the
// full shift. Rotates exist only when SHIFT_ROTATE_EN is defined; otherwise
// ROL/ROR fall into the pass-through default like any unassigned op.
module shift_stage
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LO_BIT = 0,
    parameter int HI_BIT = $clog2(XLEN) - 1
) (
    input  logic [XLEN-1:0]      data_in,
    input  op_t                  op,
    input  logic [HI_BIT:LO_BIT] shamt_part,
    input  logic                 sign,
    output logic [XLEN-1:0]      data_out
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  amt;
    logic [XLEN-1:0] fill_mask;

    // Shift the incoming partial result by this stage's share of shamt.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        amt                = '0;
        amt[HI_BIT:LO_BIT] = shamt_part;
        // SRA fill comes from the original operand's sign, not the partial data.
        fill_mask          = ~({XLEN{1'b1}} >> amt);
        data_out           = data_in;
        case (op)
            OP_SLL:  data_out = data_in << amt;
            OP_SRL:  data_out = data_in >> amt;
            OP_SRA:  data_out = (data_in >> amt) | (sign ? fill_mask : '0);
`ifdef SHIFT_ROTATE_EN
            // A shift by XLEN yields zero, so amt == 0 degenerates to data_in.
            OP_ROL:  data_out = (data_in << amt) | (data_in >> (XLEN - int'(amt)));
            OP_ROR:  data_out = (data_in >> amt) | (data_in << (XLEN - int'(amt)));
`endif
            default: data_out = data_in;
        endcase
    end

endmodule : shift_stage

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR) with
// valid/ready handshaking, full backpressure and a tag per operation.
// PIPE_STAGES=2 splits shamt: the upper half is applied before the first
// register, the lower half before the output register.
// Optional feature: define SHIFT_ROTATE_EN to build ROL/ROR.
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int XLEN        = 32,
    localparam int SHW         = $clog2(XLEN),
    parameter  int PIPE_STAGES = 2,
    parameter  int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    if ((PIPE_STAGES != 1 && PIPE_STAGES != 2) || XLEN < 8 || !is_pow2(XLEN)) begin : g_bad_cfg
        $error("shift_pipe: PIPE_STAGES must be 1 or 2 and XLEN a power of two >= 8");
    end

    // Output (last) stage. Only data and tag are needed past this point.
    logic             last_valid_q, last_valid_d;
    logic [XLEN-1:0]  last_data_q,  last_data_d;
    logic [TAG_W-1:0] last_tag_q,   last_tag_d;

    logic out_fire;
    logic last_advance;
    logic accept;

    assign out_fire     = last_valid_q && out_ready;
    // The last stage may load when it is empty or is being drained this cycle.
    assign last_advance = !last_valid_q || out_fire;
    // A request that coincides with flush is dropped, even with in_ready high.
    assign accept       = in_valid && in_ready && !flush;

    assign out_valid = last_valid_q;
    assign out_data  = last_data_q;
    assign out_tag   = last_tag_q;

    if (PIPE_STAGES == 2) begin : g_two
        // Payload between the two stages: only the low shamt half remains.
        typedef struct packed {
            logic [XLEN-1:0]  data;
            op_t              op;
            logic [SHW/2-1:0] shamt;
            logic [TAG_W-1:0] tag;
            logic             sign;
        } mid_t;

        mid_t            s1_q, s1_d;
        logic            s1_valid_q, s1_valid_d;
        logic [XLEN-1:0] st1_data;
        logic [XLEN-1:0] st2_data;

        shift_stage #(.XLEN(XLEN), .LO_BIT(SHW/2), .HI_BIT(SHW-1)) u_stage1 (
            .data_in    (in_data),
            .op         (in_op),
            .shamt_part (in_shamt[SHW-1:SHW/2]),
            .sign       (in_data[XLEN-1]),
            .data_out   (st1_data)
        );

        shift_stage #(.XLEN(XLEN), .LO_BIT(0), .HI_BIT(SHW/2-1)) u_stage2 (
            .data_in    (s1_q.data),
            .op         (s1_q.op),
            .shamt_part (s1_q.shamt),
            .sign       (s1_q.sign),
            .data_out   (st2_data)
        );

        // Stage 1 frees up when empty or when it moves into the last stage.
        assign in_ready = !s1_valid_q || last_advance;

        // Next-state for both stages: compress bubbles, then apply flush.
        always_comb begin
            s1_valid_d   = s1_valid_q;
            s1_d         = s1_q;
            last_valid_d = last_valid_q;
            last_data_d  = last_data_q;
            last_tag_d   = last_tag_q;

            if (in_ready) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_d.data  = st1_data;
                    s1_d.op    = in_op;
                    s1_d.shamt = in_shamt[SHW/2-1:0];
                    s1_d.tag   = in_tag;
                    s1_d.sign  = in_data[XLEN-1];
                end
            end

            if (last_advance) begin
                last_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    last_data_d = st2_data;
                    last_tag_d  = s1_q.tag;
                end
            end

            if (flush) begin
                s1_valid_d   = 1'b0;
                last_valid_d = 1'b0;
            end
        end

        // Stage 1 register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_q       <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_q       <= s1_d;
            end
        end
    end else begin : g_one
        logic [XLEN-1:0] st_data;

        shift_stage #(.XLEN(XLEN), .LO_BIT(0), .HI_BIT(SHW-1)) u_stage (
            .data_in    (in_data),
            .op         (in_op),
            .shamt_part (in_shamt),
            .sign       (in_data[XLEN-1]),
            .data_out   (st_data)
        );

        assign in_ready = last_advance;

        // Single stage: the full shift lands directly in the output register.
        always_comb begin
            last_valid_d = last_valid_q;
            last_data_d  = last_data_q;
            last_tag_d   = last_tag_q;

            if (last_advance) begin
                last_valid_d = accept;
                if (accept) begin
                    last_data_d = st_data;
                    last_tag_d  = in_tag;
                end
            end

            if (flush) begin
                last_valid_d = 1'b0;
            end
        end
    end

    // Output register: holds data and tag stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            last_valid_q <= 1'b0;
            last_data_q  <= '0;
            last_tag_q   <= '0;
        end else begin
            last_valid_q <= last_valid_d;
            last_data_q  <= last_data_d;
            last_tag_q   <= last_tag_d;
        end
    end

endmodule : shift_pipe
